// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, RV32I width codes and store/alignment helpers.
// No latency of its own; pure types and combinational functions.
// No flow control.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'd1:    return lane[0];
      2'd2:    return (lane != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

  // Both directions at once, or a width code with no matching RV32I opcode.
  function automatic logic is_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    logic bad_ld;
    logic bad_st;
    bad_ld = rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    bad_st = wr && (f3 > 3'd2);
    return (rd && wr) || bad_ld || bad_st;
  endfunction

  // Byte enables for the addressed lane(s); words enable all four.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'd0:    return 4'b0001 << lane;
      2'd1:    return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across every lane so byte enables alone pick it.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_align.sv
// load_align: extracts the addressed byte/halfword of a load word and extends it.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the lane, then sign- or zero-extend according to the width code.
  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store engine on a req/gnt/rvalid data bus.
// Latency: 3 stall cycles for a zero-wait access, +1 per gnt or rvalid wait cycle.
// Backpressure: stalls the pipeline until DONE; bus waits bounded by TIMEOUT.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] dmem_out,
  output logic        dmem_out_valid,
  output logic        misalign,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  // Counter only has to reach TIMEOUT-1: the cycle it sits there is the last one allowed.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_dmem_out;
  logic [31:0]   r_fault_addr;
  logic [3:0]    r_be;
  logic [2:0]    r_f3;
  logic          r_we;
  logic          r_bus_req;
  logic          r_squash;
  logic          r_res_vld;
  logic          r_misalign;
  logic          r_fault;

  logic          w_access;
  logic          w_illegal;
  logic          w_misal;
  logic          w_tmo;
  logic          w_sq;
  logic          w_done_tmo;
  logic          w_done_rsp;
  logic [31:0]   w_load;

  assign w_access  = mem_valid && (mem_read || mem_write) && !flush;
  assign w_illegal = is_illegal(mem_read, mem_write, funct3);
  assign w_misal   = is_misaligned(funct3, addr[1:0]);
  assign w_tmo     = (r_cnt == CW'(TIMEOUT - 1));
  // A flush seen at any point after the request left IDLE hides the result.
  assign w_sq      = r_squash || flush;

  load_align u_load_align (
    .i_rdata  (bus_rdata),
    .i_lane   (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_data   (w_load)
  );

  // Next state, stall, and why DONE is being entered (timeout vs. bus response).
  always_comb begin
    w_state_nxt = r_state;
    w_done_tmo  = 1'b0;
    w_done_rsp  = 1'b0;
    stall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_access;
        if (w_access) w_state_nxt = (w_illegal || w_misal) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        stall = 1'b1;
        if (flush && !bus_gnt) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmo) begin
          w_state_nxt = ST_DONE;
          w_done_tmo  = 1'b1;
        end else if (bus_gnt) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          w_state_nxt = ST_DONE;
          w_done_rsp  = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt = ST_DONE;
          w_done_tmo  = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request latch, timeout counter, load result and one-cycle DONE strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_dmem_out   <= '0;
      r_fault_addr <= '0;
      r_be         <= '0;
      r_f3         <= '0;
      r_we         <= 1'b0;
      r_bus_req    <= 1'b0;
      r_squash     <= 1'b0;
      r_res_vld    <= 1'b0;
      r_misalign   <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_bus_req  <= (w_state_nxt == ST_REQ);
      r_res_vld  <= 1'b0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
      if (r_state == ST_IDLE && w_access) begin
        r_squash <= 1'b0;
        if (w_illegal) begin
          r_fault      <= 1'b1;
          r_fault_addr <= addr;
        end else if (w_misal) begin
          r_misalign   <= 1'b1;
          r_fault_addr <= addr;
        end else begin
          r_addr  <= addr;
          r_we    <= mem_write;
          r_f3    <= funct3;
          r_be    <= store_be(funct3, addr[1:0]);
          r_wdata <= store_data(funct3, wdata);
          r_cnt   <= '0;
        end
      end
      if (r_state == ST_REQ || r_state == ST_RESP) begin
        r_cnt <= r_cnt + CW'(1);
        if (flush) r_squash <= 1'b1;
      end
      if (w_done_tmo && !w_sq) begin
        r_fault      <= 1'b1;
        r_fault_addr <= r_addr;
      end
      if (w_done_rsp && !w_sq) begin
        if (bus_err) begin
          r_fault      <= 1'b1;
          r_fault_addr <= r_addr;
        end else if (!r_we) begin
          r_res_vld  <= 1'b1;
          r_dmem_out <= w_load;
        end
      end
    end
  end

  assign dmem_out       = r_dmem_out;
  assign dmem_out_valid = r_res_vld;
  assign misalign       = r_misalign;
  assign fault          = r_fault;
  assign fault_addr     = r_fault_addr;
  assign bus_req        = r_bus_req;
  assign bus_we         = r_we;
  assign bus_addr       = {r_addr[31:2], 2'b00};
  assign bus_wdata      = r_wdata;
  assign bus_be         = r_be;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed vectors with hand-computed results for dmem_access_unit.
// The DUT is built with TIMEOUT=4 so the timeout path is reachable quickly.
// A cycle-level bus responder inside the access task drives gnt/rvalid with set waits.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, dmem_out_valid, misalign, fault;
  logic [31:0] dmem_out, fault_addr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  dmem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .flush(flush), .stall(stall),
    .dmem_out(dmem_out), .dmem_out_valid(dmem_out_valid), .misalign(misalign), .fault(fault),
    .fault_addr(fault_addr), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Results of the most recent access() call.
  int          o_stalls, o_nreq, o_hold_bad;
  logic        o_done, o_vld, o_flt, o_mis, o_we;
  logic [31:0] o_out, o_faddr, o_wd, o_baddr;
  logic [3:0]  o_be;

  // Runs one MEM-stage access starting just after a rising edge. gw/rw are the gnt and
  // rvalid wait cycles, fl is the cycle index that carries a flush (-1 for none).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gw, input int rw, input int fl,
                        input logic [31:0] rdat, input logic err);
    int   rq_w;
    int   rs_w;
    logic in_resp;
    logic seen_req;
    rq_w = 0; rs_w = 0; in_resp = 1'b0; seen_req = 1'b0;
    o_stalls = 0; o_nreq = 0; o_hold_bad = 0; o_done = 1'b0;
    o_vld = 1'b0; o_flt = 1'b0; o_mis = 1'b0; o_we = 1'b0;
    o_out = '0; o_faddr = '0; o_wd = '0; o_baddr = '0; o_be = '0;
    mem_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall) o_stalls++;
      if (bus_req) begin
        o_nreq++;
        if (!seen_req) begin
          seen_req = 1'b1;
          o_be = bus_be; o_wd = bus_wdata; o_we = bus_we; o_baddr = bus_addr;
        end else if (bus_be !== o_be || bus_wdata !== o_wd || bus_addr !== o_baddr) begin
          o_hold_bad++;
        end
      end
      if (!stall) begin
        o_done = 1'b1; o_vld = dmem_out_valid; o_out = dmem_out;
        o_flt = fault; o_mis = misalign; o_faddr = fault_addr;
        break;
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; flush = 1'b0;
      if (k == fl) begin
        flush = 1'b1;
        mem_valid = 1'b0;
      end
      if (in_resp) begin
        if (rs_w == rw) begin
          bus_rvalid = 1'b1; bus_rdata = rdat; bus_err = err; in_resp = 1'b0;
        end else rs_w++;
      end else if (bus_req) begin
        if (rq_w == gw) begin
          bus_gnt = 1'b1; in_resp = 1'b1;
        end else rq_w++;
      end
    end
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check("done_reached", 32'(o_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall",    32'(stall), 32'd0);
    check("rst_bus_req",  32'(bus_req), 32'd0);
    check("rst_dmem_out", dmem_out, 32'd0);
    check("rst_valid",    32'(dmem_out_valid), 32'd0);
    check("rst_fault",    32'(fault), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_faddr",    fault_addr, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be",   32'(bus_be), 32'd0);
    check("rst_bus_wd",   bus_wdata, 32'd0);
    check("rst_bus_we",   32'(bus_we), 32'd0);
    @(posedge clk); #1;

    // lbu from lane 3 of 0x81234567, zero-wait bus.
    access(1'b1, 1'b0, F3_BU, 32'h0000_1003, 32'h0, 0, 0, -1, 32'h8123_4567, 1'b0);
    check("lbu_out",    o_out, 32'h0000_0081);
    check("lbu_vld",    32'(o_vld), 32'd1);
    check("lbu_stalls", o_stalls, 32'd3);
    check("lbu_nreq",   o_nreq, 32'd1);
    check("lbu_baddr",  o_baddr, 32'h0000_1000);
    check("lbu_we",     32'(o_we), 32'd0);

    // lh from upper half of 0x80017FFF: sign-extended.
    access(1'b1, 1'b0, F3_H, 32'h0000_2002, 32'h0, 0, 0, -1, 32'h8001_7FFF, 1'b0);
    check("lh_out", o_out, 32'hFFFF_8001);
    check("lh_vld", 32'(o_vld), 32'd1);

    // sb to lane 1 with gnt delayed two cycles.
    access(1'b0, 1'b1, F3_B, 32'h0000_3001, 32'h0000_00AB, 2, 0, -1, 32'h0, 1'b0);
    check("sb_be",     32'(o_be), 32'h0000_0002);
    check("sb_wdata",  o_wd, 32'hABAB_ABAB);
    check("sb_we",     32'(o_we), 32'd1);
    check("sb_hold",   o_hold_bad, 32'd0);
    check("sb_nreq",   o_nreq, 32'd3);
    check("sb_stalls", o_stalls, 32'd5);
    check("sb_vld",    32'(o_vld), 32'd0);
    check("sb_out",    o_out, 32'hFFFF_8001);

    // Misaligned lw: strobe in c1, no bus activity.
    access(1'b1, 1'b0, F3_W, 32'h0000_4002, 32'h0, 0, 0, -1, 32'h0, 1'b0);
    check("mis_strobe", 32'(o_mis), 32'd1);
    check("mis_fault",  32'(o_flt), 32'd0);
    check("mis_faddr",  o_faddr, 32'h0000_4002);
    check("mis_nreq",   o_nreq, 32'd0);
    check("mis_stalls", o_stalls, 32'd1);

    // lw with no gnt: times out after 4 REQ cycles, fault in c5.
    access(1'b1, 1'b0, F3_W, 32'h0000_6000, 32'h0, 1000, 0, -1, 32'h0, 1'b0);
    check("tmo_fault",  32'(o_flt), 32'd1);
    check("tmo_faddr",  o_faddr, 32'h0000_6000);
    check("tmo_stalls", o_stalls, 32'd5);
    check("tmo_nreq",   o_nreq, 32'd4);
    check("tmo_vld",    32'(o_vld), 32'd0);
    // Late response in IDLE must be ignored.
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 bus_rvalid = 1'b0;
    @(negedge clk);
    check("late_vld", 32'(dmem_out_valid), 32'd0);
    check("late_out", dmem_out, 32'hFFFF_8001);
    @(posedge clk); #1;

    // Next load completes normally.
    access(1'b1, 1'b0, F3_W, 32'h0000_6004, 32'h0, 0, 0, -1, 32'h1234_5678, 1'b0);
    check("lw_out",    o_out, 32'h1234_5678);
    check("lw_vld",    32'(o_vld), 32'd1);
    check("lw_stalls", o_stalls, 32'd3);

    // sh to upper half.
    access(1'b0, 1'b1, F3_H, 32'h0000_2002, 32'h1234_CAFE, 0, 0, -1, 32'h0, 1'b0);
    check("sh_be",    32'(o_be), 32'h0000_000C);
    check("sh_wdata", o_wd, 32'hCAFE_CAFE);
    check("sh_out",   o_out, 32'h1234_5678);

    // Bus error response.
    access(1'b1, 1'b0, F3_W, 32'h0000_7000, 32'h0, 0, 0, -1, 32'h5555_AAAA, 1'b1);
    check("err_fault", 32'(o_flt), 32'd1);
    check("err_faddr", o_faddr, 32'h0000_7000);
    check("err_vld",   32'(o_vld), 32'd0);
    check("err_out",   o_out, 32'h1234_5678);

    // Illegal load width code 3.
    access(1'b1, 1'b0, 3'd3, 32'h0000_8000, 32'h0, 0, 0, -1, 32'h0, 1'b0);
    check("ill_fault",  32'(o_flt), 32'd1);
    check("ill_mis",    32'(o_mis), 32'd0);
    check("ill_faddr",  o_faddr, 32'h0000_8000);
    check("ill_nreq",   o_nreq, 32'd0);
    check("ill_stalls", o_stalls, 32'd1);

    // Flush after gnt: response drained, result hidden.
    access(1'b1, 1'b0, F3_W, 32'h0000_5000, 32'h0, 0, 1, 2, 32'hAAAA_5555, 1'b0);
    check("fl_stalls", o_stalls, 32'd4);
    check("fl_vld",    32'(o_vld), 32'd0);
    check("fl_fault",  32'(o_flt), 32'd0);
    check("fl_out",    o_out, 32'h1234_5678);

    // Flush before gnt: back to IDLE, request withdrawn.
    access(1'b1, 1'b0, F3_W, 32'h0000_5004, 32'h0, 5, 0, 1, 32'h0, 1'b0);
    check("flq_stalls", o_stalls, 32'd2);
    check("flq_nreq",   o_nreq, 32'd1);
    check("flq_vld",    32'(o_vld), 32'd0);

    // Reset while in RESP.
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = F3_W; addr = 32'h0000_9000;
    @(negedge clk);
    @(negedge clk);
    check("rr_req_c1", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("rr_bus_req", 32'(bus_req), 32'd0);
    check("rr_stall",   32'(stall), 32'd0);
    check("rr_out",     dmem_out, 32'd0);
    check("rr_faddr",   fault_addr, 32'd0);
    check("rr_baddr",   bus_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("rr_stale_vld", 32'(dmem_out_valid), 32'd0);
    check("rr_stale_out", dmem_out, 32'd0);
    @(posedge clk); #1;

    // lb from lane 2 of 0x00FF8000: sign-extended 0xFF.
    access(1'b1, 1'b0, F3_B, 32'h0000_1002, 32'h0, 0, 0, -1, 32'h00FF_8000, 1'b0);
    check("lb_out", o_out, 32'hFFFF_FFFF);
    check("lb_vld", 32'(o_vld), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-memory access unit for the pipelined RISC-V core. Takes the MEM-stage load/store request, runs a req/gnt/rvalid handshake with the data bus, stalls the pipeline while the access is in flight, and returns the aligned, sign/zero-extended load word. The register-file write-back path selects that word as its dmem_out source. It also reports misaligned, illegal, bus-error and timeout faults to the trap logic.

## Interface
- TIMEOUT, 255: max cycles in REQ+RESP before a timeout fault.
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- mem_valid  in  1  MEM-stage instruction valid
- mem_read  in  1  load
- mem_write  in  1  store
- funct3  in  3  RV32I width/sign code
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- flush  in  1  squash current MEM instruction
- stall  out  1  hold the pipeline (combinational)
- dmem_out  out  32  aligned/extended load result
- dmem_out_valid  out  1  one-cycle strobe: dmem_out updated this cycle
- misalign  out  1  misaligned-access strobe
- fault  out  1  access-fault strobe (bus error, timeout, illegal)
- fault_addr  out  32  addr of the faulting access
- bus_req  out  1  request (registered)
- bus_we  out  1  write request
- bus_addr  out  32  word address, addr with bits [1:0] cleared
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack (loads and stores)
- bus_rdata  in  32  read data
- bus_err  in  1  error response, qualified by bus_rvalid

## Operation
- Access = mem_valid & (mem_read | mem_write) & ~flush.
- FSM states:
  - IDLE: on access, if legal and aligned go to REQ; otherwise go to DONE with the fault latched, no bus activity.
  - REQ: bus_req=1. On gnt go to RESP. On flush before gnt go to IDLE.
  - RESP: wait for rvalid, then go to DONE.
  - DONE: present the result for one cycle, then return to IDLE.
- Illegal cases:
  - mem_read & mem_write both set.
  - Load funct3 in {3,6,7}.
  - Store funct3 > 2.
- Misaligned cases: h/hu/sh with addr[0]=1; w/sw with addr[1:0]≠0.
- Load extract uses lane = addr[1:0]:
  - lb/lbu: byte at lane, sign/zero-extended.
  - lh/lhu: halfword at addr[1], sign/zero-extended.
  - lw: full word.
- Stores:
  - sb: be=4'b0001<<addr[1:0], data = byte×4.
  - sh: be=4'b0011<<{addr[1],1'b0}, data = half×2.
  - sw: be=4'hF, data = wdata.
- bus_addr, bus_we, bus_be and bus_wdata are latched on IDLE→REQ and held stable until gnt.
- Timeout:
  - A counter clears on IDLE→REQ and increments in REQ and RESP.
  - When it reaches TIMEOUT: go to DONE with fault=1 and drop bus_req.
  - A late response arriving afterwards is ignored.
- Flush after gnt: the response is still drained. DONE then suppresses dmem_out_valid and fault.
- dmem_out holds its last value until the next successful load. Stores and faults do not update it.

## Timing
- Reset values: state=IDLE; all outputs 0, including dmem_out, fault_addr and bus_*.
- stall = (state==IDLE & access) | state==REQ | state==RESP. It is deasserted in DONE.
- Load cycle sequence with zero-wait gnt and rvalid:
  - c0: IDLE sees access, stall=1.
  - c1: bus_req=1, gnt.
  - c2: RESP, rvalid.
  - c3: DONE, dmem_out_valid=1, stall=0.
- Total is 3 stall cycles; each wait cycle on gnt or rvalid adds one.
- Misaligned/illegal access: c0 stall=1; c1 DONE with misalign or fault strobe, fault_addr=addr.
- rvalid arriving in REQ (before gnt) is ignored.
- gnt and rvalid in the same cycle is not permitted on the bus.
- Reset in any state: IDLE next edge, bus_req=0, any outstanding response discarded.
- bus_err with rvalid: fault=1 in DONE; dmem_out unchanged.

## Structure
- Package dmem_pkg holds:
  - State encoding: IDLE/REQ/RESP/DONE.
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - Misalignment check and store-lane (be/data) functions.
- Sub-module load_align: combinational (rdata, lane, funct3) → extended word. Reused by the verification reference model.

## Test plan
- lbu, addr=0x1003, rdata=0x8123_4567, zero-wait → dmem_out=0x0000_0081, valid at c3, 3 stall cycles.
- lh, addr=0x2002, rdata=0x8001_7FFF → dmem_out=0xFFFF_8001.
- sb, addr=0x3001, wdata=0x0000_00AB, gnt delayed 2 cycles → bus_be=4'b0010, bus_wdata=0xABAB_ABAB, held stable until gnt; dmem_out unchanged.
- lw, addr=0x4002 → misalign=1 at c1, fault_addr=0x4002, bus_req never asserted.
- lw with TIMEOUT=4 and no gnt → fault at cycle 5; a later rvalid is ignored; the next load completes normally.
- flush after gnt: response drained, no dmem_out_valid; rst asserted in RESP → IDLE, all outputs 0 next cycle.
